// File: rtl/multdiv_pkg.sv
// Shared types and default sizing for the multiply/divide sequencing controller.
package multdiv_pkg;

    localparam int unsigned STEP_W     = 6;
    localparam int unsigned MULT_STEPS = 16;
    localparam int unsigned DIV_STEPS  = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/multdiv_step_counter.sv
// Step counter for the multdiv datapath: up count with sync clear and a terminal compare.
module multdiv_step_counter #(
    parameter int unsigned STEP_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [STEP_W-1:0] limit,
    output logic [STEP_W-1:0] cnt,
    output logic              term_c
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + STEP_W'(1);
        end
    end

    // Equality against N-1 also covers N == 2^STEP_W, where the limit is all-ones.
    assign term_c = (cnt == limit);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide unit: LOAD, N step cycles, DONE pulse.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned STEP_W     = multdiv_pkg::STEP_W,
    parameter int unsigned MULT_STEPS = multdiv_pkg::MULT_STEPS,
    parameter int unsigned DIV_STEPS  = multdiv_pkg::DIV_STEPS
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              ctrl_mult,
    input  logic              ctrl_div,
    input  logic              dbz_i,
    input  logic              ovf_i,
    output logic              load_o,
    output logic              step_en_o,
    output logic              op_div_o,
    output logic [STEP_W-1:0] step_cnt_o,
    output logic              busy_o,
    output logic              result_rdy_o,
    output logic              exception_o
);

    localparam logic [STEP_W-1:0] MULT_LAST = STEP_W'(MULT_STEPS - 1);
    localparam logic [STEP_W-1:0] DIV_LAST  = STEP_W'(DIV_STEPS - 1);

    state_e state_q, state_d;
    logic   op_d;
    logic   exc_q, exc_d;
    logic   req;
    logic   cnt_clr, cnt_en, cnt_term;
    logic [STEP_W-1:0] cnt_limit;

    assign req       = ctrl_mult | ctrl_div;
    assign cnt_limit = op_div_o ? DIV_LAST : MULT_LAST;
    assign cnt_clr   = (state_q == ST_LOAD);
    assign cnt_en    = (state_q == ST_RUN) && !cnt_term;

    multdiv_step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk    (clk),
        .rst_n  (clr_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .limit  (cnt_limit),
        .cnt    (step_cnt_o),
        .term_c (cnt_term)
    );

    // Next state, op latch and exception latch; a new request always restarts in LOAD.
    always_comb begin
        state_d = state_q;
        op_d    = op_div_o;
        exc_d   = exc_q;
        if (req) begin
            state_d = ST_LOAD;
            op_d    = ctrl_div & ~ctrl_mult;
            exc_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: begin
                    if (dbz_i && op_div_o) begin
                        state_d = ST_DONE;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt_term) begin
                        state_d = ST_DONE;
                        if (!op_div_o) exc_d = ovf_i;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= ST_IDLE;
            op_div_o     <= 1'b0;
            exc_q        <= 1'b0;
            load_o       <= 1'b0;
            step_en_o    <= 1'b0;
            busy_o       <= 1'b0;
            result_rdy_o <= 1'b0;
            exception_o  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_div_o     <= op_d;
            exc_q        <= exc_d;
            load_o       <= (state_d == ST_LOAD);
            step_en_o    <= (state_d == ST_RUN);
            busy_o       <= (state_d == ST_LOAD) || (state_d == ST_RUN);
            result_rdy_o <= (state_d == ST_DONE);
            exception_o  <= (state_d == ST_DONE) && exc_d;
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl: latency, step sequence, exceptions, restart, reset.
module tb_multdiv_ctrl;

    localparam int unsigned STEP_W = 6;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              ctrl_mult, ctrl_div, dbz_i, ovf_i;
    logic              load_o, step_en_o, op_div_o, busy_o, result_rdy_o, exception_o;
    logic [STEP_W-1:0] step_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    multdiv_ctrl dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .dbz_i        (dbz_i),
        .ovf_i        (ovf_i),
        .load_o       (load_o),
        .step_en_o    (step_en_o),
        .op_div_o     (op_div_o),
        .step_cnt_o   (step_cnt_o),
        .busy_o       (busy_o),
        .result_rdy_o (result_rdy_o),
        .exception_o  (exception_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request and follow it to result_rdy_o, collecting what the controller did.
    task automatic run_op(input bit mult, input bit div, input bit dbz, input int ovf_step,
                          input bit exp_op, output int edges, output int steps, output int loads,
                          output bit exc, output bit seq_ok, output bit op_ok, output bit excl_ok);
        edges = 0; steps = 0; loads = 0; exc = 1'b0;
        seq_ok = 1'b1; op_ok = 1'b1; excl_ok = 1'b1;
        ctrl_mult = mult;
        ctrl_div  = div;
        dbz_i     = dbz;
        tick();
        edges     = 1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
        while (!result_rdy_o && edges < 100) begin
            if ((int'(load_o) + int'(step_en_o) + int'(result_rdy_o)) > 1) excl_ok = 1'b0;
            if (op_div_o != exp_op) op_ok = 1'b0;
            if (load_o) loads++;
            if (step_en_o) begin
                if (int'(step_cnt_o) != steps) seq_ok = 1'b0;
                steps++;
            end
            ovf_i = step_en_o && (int'(step_cnt_o) == ovf_step);
            tick();
            edges++;
        end
        if (result_rdy_o) begin
            exc = exception_o;
            if (op_div_o != exp_op) op_ok = 1'b0;
            if (load_o || step_en_o) excl_ok = 1'b0;
        end
        ovf_i = 1'b0;
        dbz_i = 1'b0;
    endtask

    task automatic check_op(input string tag, input bit mult, input bit div, input bit dbz,
                            input int ovf_step, input bit exp_op, input int exp_edges,
                            input int exp_steps, input bit exp_exc);
        int edges, steps, loads;
        bit exc, seq_ok, op_ok, excl_ok;
        run_op(mult, div, dbz, ovf_step, exp_op, edges, steps, loads, exc, seq_ok, op_ok, excl_ok);
        check({tag, " edges"}, edges, exp_edges);
        check({tag, " steps"}, steps, exp_steps);
        check({tag, " loads"}, loads, 1);
        check({tag, " exc"}, int'(exc), int'(exp_exc));
        check({tag, " step seq"}, int'(seq_ok), 1);
        check({tag, " op_div"}, int'(op_ok), 1);
        check({tag, " exclusive"}, int'(excl_ok), 1);
        tick();
        check({tag, " idle busy"}, int'(busy_o), 0);
        check({tag, " idle rdy"}, int'(result_rdy_o), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " load"}, int'(load_o), 0);
        check({tag, " step_en"}, int'(step_en_o), 0);
        check({tag, " op_div"}, int'(op_div_o), 0);
        check({tag, " step_cnt"}, int'(step_cnt_o), 0);
        check({tag, " busy"}, int'(busy_o), 0);
        check({tag, " rdy"}, int'(result_rdy_o), 0);
        check({tag, " exc"}, int'(exception_o), 0);
    endtask

    initial begin
        int  guard;
        bit  quiet;
        clr_n = 1'b0; ctrl_mult = 1'b0; ctrl_div = 1'b0; dbz_i = 1'b0; ovf_i = 1'b0;
        #23;
        check_all_zero("reset");
        clr_n = 1'b1;
        tick();
        tick();

        check_op("mult", 1'b1, 1'b0, 1'b0, -1, 1'b0, 18, 16, 1'b0);
        check_op("div", 1'b0, 1'b1, 1'b0, -1, 1'b1, 34, 32, 1'b0);
        check_op("dbz", 1'b0, 1'b1, 1'b1, -1, 1'b1, 2, 0, 1'b1);
        check_op("mult dbz ignored", 1'b1, 1'b0, 1'b1, -1, 1'b0, 18, 16, 1'b0);
        check_op("ovf last", 1'b1, 1'b0, 1'b0, 15, 1'b0, 18, 16, 1'b1);
        check_op("ovf mid", 1'b1, 1'b0, 1'b0, 7, 1'b0, 18, 16, 1'b0);
        check_op("both", 1'b1, 1'b1, 1'b0, -1, 1'b0, 18, 16, 1'b0);
        check_op("clr exc", 1'b1, 1'b0, 1'b0, -1, 1'b0, 18, 16, 1'b0);

        // Restart: divide request lands on step 5 of a multiply.
        ctrl_mult = 1'b1;
        tick();
        ctrl_mult = 1'b0;
        quiet = 1'b1;
        guard = 0;
        while (!(step_en_o && step_cnt_o == STEP_W'(5)) && guard < 50) begin
            if (result_rdy_o) quiet = 1'b0;
            tick();
            guard++;
        end
        check("restart reach step5", int'(guard < 50), 1);
        check("restart no early rdy", int'(quiet), 1);
        check_op("restart div", 1'b0, 1'b1, 1'b0, -1, 1'b1, 34, 32, 1'b0);

        // Asynchronous reset mid-RUN.
        ctrl_div = 1'b1;
        tick();
        ctrl_div = 1'b0;
        repeat (10) tick();
        check("pre-reset step_en", int'(step_en_o), 1);
        #3;
        clr_n = 1'b0;
        #1;
        check_all_zero("async reset");
        #7;
        clr_n = 1'b1;
        quiet = 1'b1;
        repeat (40) begin
            tick();
            if (load_o || step_en_o || op_div_o || busy_o || result_rdy_o || exception_o ||
                step_cnt_o != '0) quiet = 1'b0;
        end
        check("post-reset quiet", int'(quiet), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
